// File: rtl/key_event_arbiter_pkg.sv
// Shared types and constants for the keyboard key-event arbiter.
package key_event_arbiter_pkg;

  localparam int unsigned SC_W = 8;
  localparam logic [SC_W-1:0] SC_LSHIFT = 8'h12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHDN    = 3'd1,
    PRESS   = 3'd2,
    HOLD    = 3'd3,
    RELEASE = 3'd4,
    SHUP    = 3'd5,
    GAP     = 3'd6
  } state_e;

  typedef struct packed {
    logic            pressed;
    logic            extended;
    logic [SC_W-1:0] code;
  } key_event_t;

  function automatic key_event_t mk_event(input logic pressed, input logic extended,
                                          input logic [SC_W-1:0] code);
    key_event_t ev;
    ev.pressed  = pressed;
    ev.extended = extended;
    ev.code     = code;
    return ev;
  endfunction

endpackage

// File: rtl/key_event_timer.sv
// Loadable down-counter; saturates at zero and flags zero combinationally.
module key_event_timer #(
  parameter int unsigned CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign zero_c_o = (cnt_q == '0);

endmodule

// File: rtl/key_event_arbiter.sv
// Merges live PS/2 key events with sequenced autotype keystrokes into one
// registered key-event stream; live events always win the output slot.
module key_event_arbiter
  import key_event_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 1000000,
  parameter int unsigned GAP_CYCLES  = 1000000,
  parameter int unsigned CNT_W       = 21
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ps2_strobe,
  input  logic            ps2_pressed,
  input  logic            ps2_extended,
  input  logic [SC_W-1:0] ps2_code,
  input  logic            at_valid,
  output logic            at_ready,
  input  logic [SC_W-1:0] at_code,
  input  logic            at_extended,
  input  logic            at_shift,
  input  logic            at_abort,
  output logic            key_strobe,
  output logic            key_pressed,
  output logic            key_extended,
  output logic [SC_W-1:0] key_code,
  output logic            at_busy
);

  // A zero-length parameter behaves as one cycle rather than wrapping.
  localparam logic [CNT_W-1:0] HOLD_LOAD = (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0)  ? '0 : CNT_W'(GAP_CYCLES - 1);

  state_e          state_q, state_d;
  key_event_t      ev_q, ev_d;
  logic            strobe_q, strobe_d;
  logic            busy_q;
  logic [SC_W-1:0] req_code_q;
  logic            req_ext_q, req_shift_q;
  logic            aborted_q, aborted_d;
  logic            latch_en;
  logic            tmr_load, tmr_dec, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic            emit_ok;

  key_event_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_c_o   (tmr_zero)
  );

  assign at_ready = (state_q == IDLE) & ~reset;
  assign emit_ok  = ~ps2_strobe;

  // Next-state and output slot selection.
  always_comb begin
    state_d   = state_q;
    ev_d      = ev_q;
    strobe_d  = 1'b0;
    aborted_d = aborted_q;
    latch_en  = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;

    if (ps2_strobe) begin
      strobe_d = 1'b1;
      ev_d     = mk_event(ps2_pressed, ps2_extended, ps2_code);
    end

    unique case (state_q)
      IDLE: begin
        aborted_d = 1'b0;
        if (at_valid && at_ready) begin
          latch_en = 1'b1;
          state_d  = at_shift ? SHDN : PRESS;
        end
      end
      SHDN: begin
        if (at_abort) begin
          state_d = IDLE;
        end else if (emit_ok) begin
          strobe_d = 1'b1;
          ev_d     = mk_event(1'b1, 1'b0, SC_LSHIFT);
          state_d  = PRESS;
        end
      end
      PRESS: begin
        if (at_abort) begin
          aborted_d = 1'b1;
          state_d   = req_shift_q ? SHUP : IDLE;
        end else if (emit_ok) begin
          strobe_d = 1'b1;
          ev_d     = mk_event(1'b1, req_ext_q, req_code_q);
          tmr_load = 1'b1;
          tmr_val  = HOLD_LOAD;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (at_abort) begin
          aborted_d = 1'b1;
          state_d   = RELEASE;
        end else if (tmr_zero) begin
          state_d = RELEASE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      RELEASE: begin
        if (emit_ok) begin
          strobe_d = 1'b1;
          ev_d     = mk_event(1'b0, req_ext_q, req_code_q);
          if (req_shift_q) begin
            state_d = SHUP;
          end else if (aborted_q) begin
            state_d = IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = GAP;
          end
        end
      end
      SHUP: begin
        if (emit_ok) begin
          strobe_d = 1'b1;
          ev_d     = mk_event(1'b0, 1'b0, SC_LSHIFT);
          if (aborted_q) begin
            state_d = IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        if (at_abort || tmr_zero) begin
          state_d = IDLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ev_q        <= '0;
      strobe_q    <= 1'b0;
      busy_q      <= 1'b0;
      req_code_q  <= '0;
      req_ext_q   <= 1'b0;
      req_shift_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ev_q      <= ev_d;
      strobe_q  <= strobe_d;
      busy_q    <= (state_d != IDLE);
      aborted_q <= aborted_d;
      if (latch_en) begin
        req_code_q  <= at_code;
        req_ext_q   <= at_extended;
        req_shift_q <= at_shift;
      end
    end
  end

  assign key_strobe   = strobe_q;
  assign key_pressed  = ev_q.pressed;
  assign key_extended = ev_q.extended;
  assign key_code     = ev_q.code;
  assign at_busy      = busy_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed self-checking bench for key_event_arbiter (HOLD=4, GAP=3).
module tb_key_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_strobe, ps2_pressed, ps2_extended;
  logic [7:0] ps2_code;
  logic       at_valid, at_ready, at_extended, at_shift, at_abort;
  logic [7:0] at_code;
  logic       key_strobe, key_pressed, key_extended, at_busy;
  logic [7:0] key_code;

  int errs   = 0;
  int checks = 0;
  int n;

  key_event_arbiter #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .ps2_strobe   (ps2_strobe),
    .ps2_pressed  (ps2_pressed),
    .ps2_extended (ps2_extended),
    .ps2_code     (ps2_code),
    .at_valid     (at_valid),
    .at_ready     (at_ready),
    .at_code      (at_code),
    .at_extended  (at_extended),
    .at_shift     (at_shift),
    .at_abort     (at_abort),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_code     (key_code),
    .at_busy      (at_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int cnt);
    repeat (cnt) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input string tag, input int maxc, output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!key_strobe && cnt < maxc);
    chk({tag, "_seen"}, 32'(key_strobe), 32'd1);
  endtask

  task automatic wait_ready(input string tag, input int maxc, output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!at_ready && cnt < maxc);
    chk({tag, "_rdy"}, 32'(at_ready), 32'd1);
  endtask

  task automatic chk_ev(input string tag, input logic p, input logic e, input logic [7:0] c);
    chk({tag, "_code"}, 32'(key_code), 32'(c));
    chk({tag, "_prs"}, 32'(key_pressed), 32'(p));
    chk({tag, "_ext"}, 32'(key_extended), 32'(e));
  endtask

  task automatic request(input logic [7:0] c, input logic e, input logic s);
    at_code = c; at_extended = e; at_shift = s; at_valid = 1'b1;
    step(1);
    at_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ps2_strobe = 1'b0; ps2_pressed = 1'b0; ps2_extended = 1'b0; ps2_code = 8'h00;
    at_valid = 1'b0; at_code = 8'h00; at_extended = 1'b0; at_shift = 1'b0; at_abort = 1'b0;
    step(2);
    chk("rst_strobe", 32'(key_strobe), 0);
    chk_ev("rst", 1'b0, 1'b0, 8'h00);
    chk("rst_ready", 32'(at_ready), 0);
    chk("rst_busy", 32'(at_busy), 0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(at_ready), 1);

    // live event only
    ps2_strobe = 1'b1; ps2_pressed = 1'b1; ps2_code = 8'h1C;
    step(1);
    ps2_strobe = 1'b0;
    chk("live_strobe", 32'(key_strobe), 1);
    chk_ev("live", 1'b1, 1'b0, 8'h1C);
    chk("live_busy", 32'(at_busy), 0);
    step(1);
    chk("live_once", 32'(key_strobe), 0);

    // autotype without shift
    request(8'h2D, 1'b0, 1'b0);
    chk("at_acc_ready", 32'(at_ready), 0);
    chk("at_acc_busy", 32'(at_busy), 1);
    chk("at_acc_nostb", 32'(key_strobe), 0);
    wait_strobe("at_press", 3, n);
    chk("at_press_lat", n, 1);
    chk_ev("at_press", 1'b1, 1'b0, 8'h2D);
    wait_strobe("at_rel", 10, n);
    chk("at_hold_len", n, 5);
    chk_ev("at_rel", 1'b0, 1'b0, 8'h2D);
    step(2);
    chk("gap_not_ready", 32'(at_ready), 0);
    step(1);
    chk("gap_ready", 32'(at_ready), 1);
    chk("gap_busy", 32'(at_busy), 0);

    // autotype with shift
    request(8'h52, 1'b0, 1'b1);
    wait_strobe("sh_dn", 3, n);
    chk("sh_dn_lat", n, 1);
    chk_ev("sh_dn", 1'b1, 1'b0, 8'h12);
    chk("sh_dn_busy", 32'(at_busy), 1);
    wait_strobe("sh_pr", 3, n);
    chk("sh_pr_lat", n, 1);
    chk_ev("sh_pr", 1'b1, 1'b0, 8'h52);
    wait_strobe("sh_rl", 10, n);
    chk("sh_rl_lat", n, 5);
    chk_ev("sh_rl", 1'b0, 1'b0, 8'h52);
    chk("sh_rl_busy", 32'(at_busy), 1);
    wait_strobe("sh_up", 3, n);
    chk("sh_up_lat", n, 1);
    chk_ev("sh_up", 1'b0, 1'b0, 8'h12);
    chk("sh_up_busy", 32'(at_busy), 1);
    wait_ready("sh_gap", 10, n);
    chk("sh_gap_len", n, 3);

    // collision between live event and PRESS emit
    request(8'h2D, 1'b0, 1'b0);
    ps2_strobe = 1'b1; ps2_pressed = 1'b1; ps2_code = 8'h29;
    step(1);
    ps2_strobe = 1'b0;
    chk("col_live", 32'(key_strobe), 1);
    chk_ev("col_live", 1'b1, 1'b0, 8'h29);
    step(1);
    chk("col_at", 32'(key_strobe), 1);
    chk_ev("col_at", 1'b1, 1'b0, 8'h2D);
    wait_strobe("col_rel", 10, n);
    chk("col_hold_len", n, 5);
    chk_ev("col_rel", 1'b0, 1'b0, 8'h2D);
    wait_ready("col_gap", 10, n);

    // abort in HOLD with shift: release, shift-up, no gap
    request(8'h52, 1'b0, 1'b1);
    wait_strobe("ab_dn", 3, n);
    wait_strobe("ab_pr", 3, n);
    chk_ev("ab_pr", 1'b1, 1'b0, 8'h52);
    at_abort = 1'b1;
    step(1);
    at_abort = 1'b0;
    chk("ab_nostb", 32'(key_strobe), 0);
    step(1);
    chk("ab_rel", 32'(key_strobe), 1);
    chk_ev("ab_rel", 1'b0, 1'b0, 8'h52);
    step(1);
    chk("ab_up", 32'(key_strobe), 1);
    chk_ev("ab_up", 1'b0, 1'b0, 8'h12);
    chk("ab_ready", 32'(at_ready), 1);
    chk("ab_busy", 32'(at_busy), 0);

    // abort in GAP returns straight to IDLE
    request(8'h2D, 1'b0, 1'b0);
    wait_strobe("ag_pr", 3, n);
    wait_strobe("ag_rl", 10, n);
    chk("ag_gap_wait", 32'(at_ready), 0);
    at_abort = 1'b1;
    step(1);
    at_abort = 1'b0;
    chk("ag_ready", 32'(at_ready), 1);

    // extended key, then reset during HOLD
    request(8'h75, 1'b1, 1'b0);
    wait_strobe("rs_pr", 3, n);
    chk_ev("rs_pr", 1'b1, 1'b1, 8'h75);
    step(1);
    reset = 1'b1;
    ps2_strobe = 1'b1; ps2_pressed = 1'b1; ps2_code = 8'h33;
    step(1);
    ps2_strobe = 1'b0;
    chk("rs_strobe", 32'(key_strobe), 0);
    chk_ev("rs", 1'b0, 1'b0, 8'h00);
    chk("rs_busy", 32'(at_busy), 0);
    chk("rs_ready_in_rst", 32'(at_ready), 0);
    reset = 1'b0;
    #1;
    chk("rs_ready", 32'(at_ready), 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (key_strobe) n++;
    end
    chk("rs_no_release", n, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Shares the single key-event input of the CPC keyboard matrix (strobe/pressed/extended/code) between two requesters: the live PS/2 keyboard decoder and an autotype source (OSD/loader typing commands such as RUN").
- Live events always take priority and are forwarded with fixed latency.
- Autotype requests arrive one scan code at a time. The block sequences each into optional LShift-down, key-down, hold, key-up, optional LShift-up and inter-key gap.
- Sits between the PS/2 decoder / autotype FIFO and the keyboard matrix block.

Parameters:
HOLD_CYCLES, 1000000, clock cycles the autotyped key is held down (40 ms at 25 MHz)
GAP_CYCLES, 1000000, clock cycles of idle after each autotyped key's release
CNT_W, 21, timer width; must hold max(HOLD_CYCLES, GAP_CYCLES)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-high
ps2_strobe  in  1  one-cycle live key event
ps2_pressed  in  1  live event: 1 = make, 0 = break
ps2_extended  in  1  live event E0 prefix
ps2_code  in  8  live scan code
at_valid  in  1  autotype request valid
at_ready  out  1  autotype request accepted this cycle
at_code  in  8  autotype scan code
at_extended  in  1  autotype code is E0-extended
at_shift  in  1  wrap the key in LShift (code 8'h12) press/release
at_abort  in  1  abort the current autotype key
key_strobe  out  1  merged event strobe to keyboard matrix
key_pressed  out  1  merged event make/break
key_extended  out  1  merged event extended flag
key_code  out  8  merged event scan code
at_busy  out  1  autotype sequence in progress (state != IDLE)

Behaviour:
- Outputs are registered. Reset values: key_strobe=0, key_pressed=0, key_extended=0, key_code=0, at_ready=0, at_busy=0. State=IDLE, timer=0, latched request cleared.
- Live path: ps2_strobe at cycle N gives key_strobe=1 at N+1, carrying the ps2 fields. Live events are never dropped or delayed.
- Autotype emit slots: SHDN, PRESS, RELEASE, SHUP. Each emits one strobe only on a cycle with ps2_strobe=0. On collision the FSM stays in that state and retries next cycle. key_strobe is never high for two sources in one cycle.
- Emit slot contents:
  - SHDN: code 12, pressed=1, extended=0.
  - PRESS: latched code/extended, pressed=1.
  - RELEASE: latched code/extended, pressed=0.
  - SHUP: code 12, pressed=0, extended=0.
- at_ready is combinationally (state==IDLE & ~reset) and is not registered. Handshake completes when at_valid & at_ready; the block latches code, extended and shift. at_code/at_extended/at_shift must be held stable while at_valid=1 and at_ready=0.
- FSM: IDLE -> (accept) SHDN if shift else PRESS.
  - SHDN -> PRESS after emit.
  - PRESS -> HOLD after emit; timer loaded with HOLD_CYCLES-1.
  - HOLD -> RELEASE when timer==0 (decrement each cycle).
  - RELEASE -> SHUP if shift else GAP.
  - SHUP -> GAP; timer loaded with GAP_CYCLES-1.
  - GAP -> IDLE when timer==0.
- Key-down duration from PRESS strobe to RELEASE strobe: HOLD_CYCLES+1 cycles, plus any collision retries.
- Parameter value of 0 is treated as 1 (no underflow wrap).
- at_abort:
  - In SHDN or PRESS before emit: go to SHUP if SHDN already emitted, otherwise IDLE.
  - In HOLD: go to RELEASE immediately.
  - In GAP: go to IDLE.
  - In IDLE, RELEASE or SHUP: ignored.
  - A key already pressed is always released, and Shift is always released, before IDLE.
  - Abort skips GAP except when aborting from GAP itself.
- Reset mid-sequence: FSM returns to IDLE, no release emitted. The matrix clears its own state on reset.
- A pending live strobe during reset is discarded.

Decomposition:
- Shared package: scan-code constants (SC_LSHIFT=8'h12), FSM state enum (IDLE, SHDN, PRESS, HOLD, RELEASE, SHUP, GAP), event struct fields.
- One natural sub-module: key_event_timer, a load/decrement/zero-flag counter of CNT_W bits.

Test Plan:
- Live only: ps2_strobe with code 1C, pressed=1 at cycle 10 -> key_strobe=1, key_code=1C, key_pressed=1 at cycle 11 only; at_busy stays 0.
- Autotype, no shift, HOLD=4, GAP=3: accept code 2D -> strobe press 2D, release 2D exactly 5 cycles later; at_ready reasserts 3 cycles after the GAP entry point.
- Autotype with shift, code 52: strobe sequence is 12 make, 52 make, 52 break, 12 break, each with pressed/extended values as specified; at_busy is 1 throughout.
- Collision: ps2_strobe (code 29) in the same cycle as the PRESS emit -> 29 forwarded next cycle; autotype press emitted one cycle later; no lost or merged events.
- Abort in HOLD with shift: -> immediate 52 break, then 12 break, then IDLE with no gap; at_ready=1 the cycle after the SHUP emit.
- Reset asserted during HOLD -> all outputs 0 the next cycle; state IDLE; at_ready=1 once reset deasserts.
